// File: rtl/tx_serial_pkg.sv
// tx_serial_pkg: parity-mode codes and FSM state encoding shared by the serial transmitter.
package tx_serial_pkg;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} estado_t;
endpackage

// File: rtl/gerador_tick_baud.sv
// gerador_tick_baud: bit-period counter; tick is high on the last clock of each bit.
module gerador_tick_baud #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  output logic tick
);
  logic [CNT_W-1:0] r_cnt;
  assign tick = r_cnt == CNT_W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clock)
    if (!reset || zera || tick) r_cnt <= '0;
    else r_cnt <= r_cnt + CNT_W'(1);
endmodule

// File: rtl/tx_serial_uart_n.sv
// tx_serial_uart_n: serial transmitter (start, data LSB first, optional parity, stop bits).
// Define TX_SERIAL_BUFFER_EN to add a one-entry holding register for gapless back-to-back frames.
module tx_serial_uart_n
  import tx_serial_pkg::*;
#(
  parameter int DATA_BITS    = 7,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 partida,
  input  logic [DATA_BITS-1:0] dados,
  input  logic [1:0]           modo_paridade,
  output logic                 saida_serial,
  output logic                 ocupado,
  output logic                 pronto
);
  estado_t r_estado, w_estado;
  logic [DATA_BITS-1:0] r_shift, w_shift, w_src_d;
  logic [1:0] w_src_m;
  logic [3:0] r_idx, w_idx;
  logic r_par_en, r_par_bit, r_saida, r_pronto;
  logic w_tick, w_zera, w_fim, w_aceita, w_inicia, w_ult_dado, w_ult_stop, w_linha;

  assign w_zera = r_estado == IDLE;
  gerador_tick_baud #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_tick (
    .clock(clock),
    .reset(reset),
    .zera(w_zera),
    .tick(w_tick)
  );

  assign w_ult_dado = r_idx == 4'(DATA_BITS - 1);
  assign w_ult_stop = r_idx == 4'(STOP_BITS - 1);
  assign w_fim      = r_estado == STOP && w_tick && w_ult_stop;
  assign w_aceita   = partida && !ocupado;

`ifdef TX_SERIAL_BUFFER_EN
  logic [DATA_BITS-1:0] r_buf_d;
  logic [1:0] r_buf_m;
  logic r_buf_cheio;
  assign ocupado  = r_estado != IDLE && r_buf_cheio;
  // a request arriving exactly as the frame ends skips the buffer and starts directly
  assign w_inicia = (r_estado == IDLE && w_aceita) || (w_fim && (r_buf_cheio || w_aceita));
  assign w_src_d  = r_buf_cheio ? r_buf_d : dados;
  assign w_src_m  = r_buf_cheio ? r_buf_m : modo_paridade;
  always_ff @(posedge clock)
    if (!reset) r_buf_cheio <= 1'b0;
    else if (w_fim && r_buf_cheio) r_buf_cheio <= 1'b0;
    else if (w_aceita && r_estado != IDLE && !w_fim) begin
      r_buf_cheio <= 1'b1;
      r_buf_d     <= dados;
      r_buf_m     <= modo_paridade;
    end
`else
  assign ocupado  = r_estado != IDLE;
  assign w_inicia = w_aceita;
  assign w_src_d  = dados;
  assign w_src_m  = modo_paridade;
`endif

  always_comb begin
    w_estado = r_estado;
    w_idx    = r_idx;
    if (w_tick)
      case (r_estado)
        START:   begin w_estado = DATA; w_idx = '0; end
        DATA:    begin
          w_estado = w_ult_dado ? (r_par_en ? PARITY : STOP) : DATA;
          w_idx    = w_ult_dado ? '0 : r_idx + 4'd1;
        end
        PARITY:  begin w_estado = STOP; w_idx = '0; end
        STOP:    begin
          w_estado = w_ult_stop ? IDLE : STOP;
          w_idx    = w_ult_stop ? '0 : r_idx + 4'd1;
        end
        default: ;
      endcase
    if (w_inicia) w_estado = START;
  end

  assign w_shift = (r_estado == DATA && w_tick) ? r_shift >> 1 : r_shift;
  assign w_linha = w_estado == START  ? 1'b0 :
                   w_estado == DATA   ? w_shift[0] :
                   w_estado == PARITY ? r_par_bit : 1'b1;

  always_ff @(posedge clock)
    if (!reset) begin
      r_estado  <= IDLE;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_saida   <= 1'b1;
      r_pronto  <= 1'b0;
    end else begin
      r_estado  <= w_estado;
      r_idx     <= w_idx;
      r_shift   <= w_inicia ? w_src_d : w_shift;
      r_par_en  <= w_inicia ? (w_src_m == PAR_EVEN || w_src_m == PAR_ODD) : r_par_en;
      r_par_bit <= w_inicia ? ((w_src_m == PAR_ODD) ^ (^w_src_d)) : r_par_bit;
      r_saida   <= w_linha;
      r_pronto  <= w_fim;
    end

  assign saida_serial = r_saida;
  assign pronto       = r_pronto;
endmodule

// File: tb/tb_tx_serial_uart_n.sv
// tb_tx_serial_uart_n: checks two transmitter configurations against a frame-queue reference model.
module tb_tx_serial_uart_n;
  localparam int CPB = 4;
`ifdef TX_SERIAL_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;

  logic a_rst = 1'b0, a_go = 1'b0, a_line, a_busy, a_done;
  logic [6:0] a_d = '0;
  logic [1:0] a_m = '0;
  logic b_rst = 1'b0, b_go = 1'b0, b_line, b_busy, b_done;
  logic [7:0] b_d = '0;
  logic [1:0] b_m = '0;

  tx_serial_uart_n u_a (
    .clock(clk), .reset(a_rst), .partida(a_go), .dados(a_d), .modo_paridade(a_m),
    .saida_serial(a_line), .ocupado(a_busy), .pronto(a_done));
  tx_serial_uart_n #(.DATA_BITS(8), .STOP_BITS(2)) u_b (
    .clock(clk), .reset(b_rst), .partida(b_go), .dados(b_d), .modo_paridade(b_m),
    .saida_serial(b_line), .ocupado(b_busy), .pronto(b_done));

  // reference: each queue holds the remaining line value per clock of the current/pending frame
  bit qa[$], ba[$], qb[$], bb[$];
  bit ea_done = 1'b0, eb_done = 1'b0;

  function automatic void frame_bits(input logic [8:0] d, input int nb, input int sb,
                                     input logic [1:0] m, output bit f[$]);
    int ones = 0;
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin bits.push_back(d[i]); ones += int'(d[i]); end
    if (m == 2'b01) bits.push_back(ones % 2 == 1);
    if (m == 2'b10) bits.push_back(ones % 2 == 0);
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    f.delete();
    foreach (bits[i]) for (int j = 0; j < CPB; j++) f.push_back(bits[i]);
  endfunction

  function automatic bit xa_line(); return qa.size() > 0 ? qa[0] : 1'b1; endfunction
  function automatic bit xa_busy(); return qa.size() > 0 && (!BUF || ba.size() > 0); endfunction
  function automatic bit xb_line(); return qb.size() > 0 ? qb[0] : 1'b1; endfunction
  function automatic bit xb_busy(); return qb.size() > 0 && (!BUF || bb.size() > 0); endfunction

  always @(posedge clk) begin : model_a
    bit busy, act, fin;
    bit f[$];
    busy = xa_busy();
    if (!a_rst) begin qa.delete(); ba.delete(); ea_done = 1'b0; end
    else begin
      act = qa.size() > 0;
      if (act) void'(qa.pop_front());
      fin = act && qa.size() == 0;
      if (a_go && !busy) begin
        frame_bits({2'b00, a_d}, 7, 1, a_m, f);
        if (qa.size() == 0) qa = f; else ba = f;
      end
      if (qa.size() == 0 && ba.size() > 0) begin qa = ba; ba.delete(); end
      ea_done = fin;
    end
  end

  always @(posedge clk) begin : model_b
    bit busy, act, fin;
    bit f[$];
    busy = xb_busy();
    if (!b_rst) begin qb.delete(); bb.delete(); eb_done = 1'b0; end
    else begin
      act = qb.size() > 0;
      if (act) void'(qb.pop_front());
      fin = act && qb.size() == 0;
      if (b_go && !busy) begin
        frame_bits({1'b0, b_d}, 8, 2, b_m, f);
        if (qb.size() == 0) qb = f; else bb = f;
      end
      if (qb.size() == 0 && bb.size() > 0) begin qb = bb; bb.delete(); end
      eb_done = fin;
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({a_line, a_busy, a_done} !== 3'b100) begin
      errors++; $display("FAIL reset_a got=%b exp=100", {a_line, a_busy, a_done});
    end
    checks++;
    if ({b_line, b_busy, b_done} !== 3'b100) begin
      errors++; $display("FAIL reset_b got=%b exp=100", {b_line, b_busy, b_done});
    end
    a_rst = 1'b1; b_rst = 1'b1;
    step();
  endtask

  task automatic test_frame_a(input string tag, input logic [6:0] d, input logic [1:0] m,
                              input int len, input logic [10:0] pat);
    logic [10:0] s = '0;
    int pc = 0;
    a_d = d; a_m = m; a_go = 1'b1;
    step();
    a_go = 1'b0; a_d = 7'($urandom); a_m = 2'($urandom);
    for (int k = 1; k <= len + 1; k++) begin
      checks++;
      if ({a_line, a_busy, a_done} !== {xa_line(), xa_busy(), ea_done}) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", tag, k, {a_line, a_busy, a_done},
                 {xa_line(), xa_busy(), ea_done});
      end
      if (k <= len && (k - 1) % CPB == 1) s[(k - 1) / CPB] = a_line;
      if (a_done && pc == 0) pc = k;
      step();
    end
    checks++;
    if (pc !== len + 1) begin errors++; $display("FAIL %s_pronto got=%0d exp=%0d", tag, pc, len + 1); end
    checks++;
    if (s !== pat) begin errors++; $display("FAIL %s_bits got=%b exp=%b", tag, s, pat); end
  endtask

  task automatic test_params_b();
    logic [10:0] s = '0;
    int pc = 0;
    b_d = 8'h55; b_m = 2'b00; b_go = 1'b1;
    step();
    b_go = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      checks++;
      if ({b_line, b_busy, b_done} !== {xb_line(), xb_busy(), eb_done}) begin
        errors++;
        $display("FAIL params cyc=%0d got=%b exp=%b", k, {b_line, b_busy, b_done},
                 {xb_line(), xb_busy(), eb_done});
      end
      if (k <= 44 && (k - 1) % CPB == 1) s[(k - 1) / CPB] = b_line;
      if (b_done && pc == 0) pc = k;
      if (k == 10) begin b_go = 1'b1; b_d = 8'hAA; end
      if (k == 11) b_go = 1'b0;
      step();
    end
    checks++;
    if (pc !== 45) begin errors++; $display("FAIL params_pronto got=%0d exp=45", pc); end
    checks++;
    if (s !== 11'b11010101010) begin errors++; $display("FAIL params_bits got=%b exp=11010101010", s); end
  endtask

  task automatic test_back_to_back();
    int p1 = 0, p2 = 0, n = 0;
    logic [1:0] gap = '0;
    a_d = 7'h41; a_m = 2'b01; a_go = 1'b1;
    step();
    for (int k = 1; k <= 200; k++) begin
      checks++;
      if ({a_line, a_busy, a_done} !== {xa_line(), xa_busy(), ea_done}) begin
        errors++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", k, {a_line, a_busy, a_done},
                 {xa_line(), xa_busy(), ea_done});
      end
      if (a_done) begin n++; if (p1 == 0) p1 = k; else if (p2 == 0) p2 = k; end
      if (k == 41) gap[1] = a_line;
      if (k == 42) gap[0] = a_line;
      if (k == 82) a_go = 1'b0;
      step();
    end
    checks++;
    if (p1 !== 41 || p2 !== (BUF ? 81 : 82)) begin
      errors++; $display("FAIL b2b_pronto got=%0d,%0d exp=41,%0d", p1, p2, BUF ? 81 : 82);
    end
    checks++;
    if (gap !== (BUF ? 2'b00 : 2'b10)) begin
      errors++; $display("FAIL b2b_gap got=%b exp=%b", gap, BUF ? 2'b00 : 2'b10);
    end
    checks++;
    if (n !== (BUF ? 4 : 2)) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", n, BUF ? 4 : 2); end
  endtask

  task automatic test_buffer();
    int n = 0;
    logic b5 = 1'b0, b6 = 1'b0, l41 = 1'b0;
    a_d = 7'h41; a_m = 2'b01; a_go = 1'b1;
    step();
    a_go = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      checks++;
      if ({a_line, a_busy, a_done} !== {xa_line(), xa_busy(), ea_done}) begin
        errors++;
        $display("FAIL buffer cyc=%0d got=%b exp=%b", k, {a_line, a_busy, a_done},
                 {xa_line(), xa_busy(), ea_done});
      end
      if (a_done) n++;
      if (k == 5) begin b5 = a_busy; a_d = 7'h42; a_go = 1'b1; end
      if (k == 6) begin b6 = a_busy; a_go = 1'b0; end
      if (k == 41) l41 = a_line;
      step();
    end
    checks++;
    if ({b5, b6} !== {!BUF, 1'b1}) begin
      errors++; $display("FAIL buffer_busy got=%b exp=%b", {b5, b6}, {!BUF, 1'b1});
    end
    checks++;
    if (l41 !== !BUF) begin errors++; $display("FAIL buffer_gap got=%b exp=%b", l41, !BUF); end
    checks++;
    if (n !== (BUF ? 2 : 1)) begin errors++; $display("FAIL buffer_count got=%0d exp=%0d", n, BUF ? 2 : 1); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    a_d = 7'($urandom); a_m = 2'b01; a_go = 1'b1;
    step();
    a_go = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if ({a_line, a_busy, a_done} !== {xa_line(), xa_busy(), ea_done}) begin
        errors++;
        $display("FAIL abort cyc=%0d got=%b exp=%b", k, {a_line, a_busy, a_done},
                 {xa_line(), xa_busy(), ea_done});
      end
      if (k == 10) a_rst = 1'b0;
      step();
    end
    checks++;
    if ({a_line, a_busy, a_done} !== 3'b100) begin
      errors++; $display("FAIL abort_state got=%b exp=100", {a_line, a_busy, a_done});
    end
    a_rst = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (a_done) n++;
      step();
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL abort_pronto got=%0d exp=0", n); end
  endtask

  task automatic test_random();
    int na = 0, ma = 0, nb = 0, mb = 0;
    for (int k = 0; k < 600; k++) begin
      checks++;
      if ({a_line, a_busy, a_done, b_line, b_busy, b_done} !==
          {xa_line(), xa_busy(), ea_done, xb_line(), xb_busy(), eb_done}) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b exp=%b", k, {a_line, a_busy, a_done, b_line, b_busy, b_done},
                 {xa_line(), xa_busy(), ea_done, xb_line(), xb_busy(), eb_done});
      end
      na += int'(a_done); ma += int'(ea_done); nb += int'(b_done); mb += int'(eb_done);
      a_go = k < 450 && $urandom_range(0, 5) == 0;
      b_go = k < 450 && $urandom_range(0, 7) == 0;
      a_d = 7'($urandom); a_m = 2'($urandom);
      b_d = 8'($urandom); b_m = 2'($urandom);
      step();
    end
    checks++;
    if (na !== ma || nb !== mb || ma == 0) begin
      errors++; $display("FAIL random_pronto got=%0d,%0d exp=%0d,%0d", na, nb, ma, mb);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a("even", 7'h41, 2'b01, 40, 11'b01010000010);
    test_frame_a("odd", 7'h41, 2'b10, 40, 11'b01110000010);
    test_frame_a("none", 7'h41, 2'b00, 36, 11'b00110000010);
    test_frame_a("resv", 7'h41, 2'b11, 36, 11'b00110000010);
    test_params_b();
    test_back_to_back();
    test_buffer();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tx_serial_uart_n.md
Name: tx_serial_uart_n

Overview:
- Parametrised asynchronous serial transmitter: control FSM, datapath and baud-tick counter in one block.
- Configurable data width, parity mode (none/even/odd, selected at run time) and stop-bit count.
- Start/ready handshake toward the host logic; drives the sonar's serial line.
- Successor to the fixed 7E1 transmitter; generalises frame format and adds back-to-back operation.

Parameters:
- DATA_BITS, 7, data bits per frame (legal 5..9).
- STOP_BITS, 1, stop bits per frame (legal 1 or 2).
- CLKS_PER_BIT, 4, clock cycles per serial bit (legal >= 2).
- CNT_W, 16, width of the baud counter (must hold CLKS_PER_BIT-1).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clock edge).
- partida  input  1  start request, sampled each cycle.
- dados  input  DATA_BITS  character to send, LSB first on the line.
- modo_paridade  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
- saida_serial  output  1  registered serial line, idles high.
- ocupado  output  1  1 = partida is ignored this cycle.
- pronto  output  1  one-cycle pulse after the last stop bit of a frame completes.

Behaviour:
- Reset (reset=0 at edge): saida_serial=1, ocupado=0, pronto=0, FSM=IDLE, baud counter=0, buffer empty.
- Reset mid-frame aborts the frame; the line is high from the next edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: partida=1 and ocupado=0 at an edge.
  - dados and modo_paridade are latched into the shift register.
  - Parity is computed at accept: even = ^dados, odd = ~^dados.
  - Next cycle: state=START, saida_serial=0, ocupado=1.
- Every bit (start, each data bit, parity, each stop bit) lasts exactly CLKS_PER_BIT cycles.
  - The counter runs 0..CLKS_PER_BIT-1; the state/bit advances when the counter reaches CLKS_PER_BIT-1.
- Transitions:
  - START -> DATA.
  - DATA shifts LSB first for DATA_BITS bits, then -> PARITY if the mode is 01/10, else -> STOP.
  - PARITY -> STOP.
  - STOP lasts STOP_BITS bit times, then -> IDLE.
- Frame length in cycles = CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS), where P = 1 if parity is enabled.
- pronto=1 for exactly the one cycle immediately after the final stop-bit period (first IDLE cycle); ocupado=0 in that same cycle.
- partida held high: a new accept occurs in the pronto cycle, giving exactly one idle-high cycle between frames.
- partida while ocupado=1: ignored, with no effect on the frame in progress.
- Input changes after accept do not affect the frame in progress.

Optional Feature:
- Macro: TX_SERIAL_BUFFER_EN.
- Defined:
  - Adds a one-entry holding register (data + mode).
  - While a frame is in flight and the buffer is empty, ocupado=0 and partida loads the buffer; ocupado then stays 1.
  - At the end of the last stop bit with the buffer full: the buffer moves to the shift register and START begins on the very next cycle, with no idle gap.
  - pronto still pulses once per completed frame, in the cycle the next START begins.
  - The buffer empties on reset.
- Undefined: no buffer; ocupado=1 for the whole frame, as in Behaviour.

Decomposition:
- Package tx_serial_pkg:
  - Parity-mode constants PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10.
  - FSM state encoding constants.
- One natural sub-module: gerador_tick_baud.
  - Parameter CLKS_PER_BIT.
  - Inputs clock, reset, zera.
  - Output tick, high on the last cycle of each bit period.
  - Reused by the future receiver.

Test Plan:
- Defaults, even parity, dados=7'h41, one partida pulse -> line LSB first 0,1,0,0,0,0,0,1,0(par),1, each bit held 4 cycles; pronto pulses at cycle 41 after accept.
- Same frame with modo_paridade=10 (odd) -> parity bit=1; with 00 -> no parity bit, 36-cycle frame, pronto at cycle 37.
- DATA_BITS=8, STOP_BITS=2, mode 00, dados=8'h55 -> 0,1,0,1,0,1,0,1,0,1,1 (bits 2 to 9 are data 0x55 LSB first, 1,0,1,0,1,0,1,0), 44 cycles; partida pulsed mid-frame is ignored.
- partida held high, two frames without buffer -> exactly one idle-high cycle between the last stop bit and the next start bit; pronto once per frame.
- reset=0 at cycle 10 of a frame -> saida_serial=1, ocupado=0, pronto=0 the next cycle; no pronto is ever emitted for the aborted frame.
- TX_SERIAL_BUFFER_EN: second partida (dados=7'h42) during frame 1 -> ocupado=1 after load; frame 2 start bit in the cycle after frame 1's stop bit, zero gap; two pronto pulses.
